// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 16-way round-robin serial mux arbiter.
//   N_REQ   : number of requesters sharing the mux
//   SEL_W   : width of the mux select / requester index
//   state_t : arbiter FSM states
//   onehot16: index -> one-hot grant vector
package mux_arb_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/MUX16to1.sv
// Gate-level 16:1 single-bit mux (AND-OR form).
//   in_i  [15:0] : data inputs
//   sel_i [3:0]  : select
//   raw_o        : in_i[sel_i]
module MUX16to1
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] in_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic             raw_o
);

    logic [N_REQ-1:0] term;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_term
            assign term[gi] = in_i[gi] & (sel_i == SEL_W'(gi));
        end
    endgenerate

    assign raw_o = |term;

endmodule

// File: rtl/rr_pick16.sv
// Combinational round-robin pick over 16 requests.
//   req_i [15:0] : request vector
//   ptr_i [3:0]  : highest-priority index this round
//   idx_o [3:0]  : first set request found scanning ptr, ptr+1, ... wrapping
//   any_o        : at least one request is set
// The request vector is rotated so ptr lands at bit 0, priority-encoded
// from bit 0 upward, and the offset is added back to ptr (mod 16).
module rr_pick16
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             any_o
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [SEL_W-1:0]   offset;

    // rot[k] = req[(ptr+k) mod 16]; the doubled vector avoids a wrap mux
    assign req_dbl = {req_i, req_i};
    assign req_rot = req_dbl[ptr_i +: N_REQ];

    // Scan downward so the lowest set bit wins
    always_comb begin
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = SEL_W'(i);
            end
        end
    end

    assign idx_o = offset + ptr_i;
    assign any_o = |req_i;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter that time-shares one 16:1 bit mux between 16 serial
// requesters. A grant lasts until the owner signals last, drops req, or
// reaches HOLD_MAX beats; one IDLE bubble separates consecutive grants.
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   req[15:0] : request per requester, held high for the burst
//   last[15:0]: last-beat flag, only the granted index is looked at
//   in[15:0]  : serial data bit per requester
//   grant     : registered one-hot grant (zero when idle)
//   sel       : registered granted index, drives the mux select
//   busy      : registered, high while a grant is held
//   out       : in[sel] gated by out_valid
//   out_valid : busy & req[sel], one transferred beat per cycle
module mux16_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    input  logic [N_REQ-1:0] in,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             out,
    output logic             out_valid
);

    localparam int                CNT_W    = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] ptr_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic [SEL_W-1:0] ptr_d;
    logic [CNT_W-1:0] cnt_d;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_req;
    logic             final_beat;
    logic             mux_raw;

    rr_pick16 u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    MUX16to1 u_mux (
        .in_i  (in),
        .sel_i (sel_q),
        .raw_o (mux_raw)
    );

    // After any release the search restarts just past the previous owner
    assign ptr_d      = sel_q + SEL_W'(1);
    assign cnt_d      = cnt_q + CNT_W'(1);
    assign owner_req  = req[sel_q];
    // Owner dropping req takes precedence; that path is checked first below
    assign final_beat = last[sel_q] | (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q <= GRANT;
                        grant_q <= onehot16(pick_idx);
                        sel_q   <= pick_idx;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req || final_beat) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign out_valid = busy_q & owner_req;
    assign out       = mux_raw & out_valid;

endmodule
